shadow_dispatch: RTL and testbench

SHADOW_DISPATCH -- requirements
Module: shadow_dispatch

---
 rtl/shadow_dispatch_pkg.sv | 42 ++++
 rtl/shadow_dispatch_color.sv | 22 ++
 rtl/shadow_dispatch.sv | 129 ++++++++++++
 tb/tb_shadow_dispatch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_dispatch_pkg.sv
// Shared fragment, ray and colour types plus the dispatch FSM state encoding.
package shadow_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_None,
        ST_Diffuse,
        ST_Mirror
    } SurfaceType_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } RGB8;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Vec3;

    typedef struct packed {
        Vec3 Origin;
        Vec3 Direction;
    } Ray;

    typedef struct packed {
        Vec3          Position;
        Vec3          Normal;
        RGB8          Color;
        SurfaceType_t SurfaceType;
        Ray           ShadowingRay;
    } RasterOutputData;

    typedef enum logic [1:0] {
        SDS_Idle,
        SDS_Issue,
        SDS_Wait,
        SDS_Output
    } ShadowDispatchState;

endpackage

// File: rtl/shadow_dispatch_color.sv
// Darkens an occluded fragment: each 8-bit channel shifted right with zero fill.
// Purely combinational; passes the colour through untouched when hit is low.
module ShadowColorApply
    import shadow_dispatch_pkg::*;
#(
    parameter int SHADOW_SHIFT = 1
) (
    input  RGB8  color_in,
    input  logic hit,
    output RGB8  color_out
);

    always_comb begin
        color_out = color_in;
        if (hit) begin
            color_out.r = color_in.r >> SHADOW_SHIFT;
            color_out.g = color_in.g >> SHADOW_SHIFT;
            color_out.b = color_in.b >> SHADOW_SHIFT;
        end
    end

endmodule

// File: rtl/shadow_dispatch.sv
// Queues raster fragments, sends lit ones through the shadow tester, darkens occluded ones.
// ST_None fragments emerge 2 edges after acceptance; fifo_full is registered, so pushes seen while full are dropped.
module shadow_dispatch
    import shadow_dispatch_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int SHADOW_SHIFT = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            add_input,
    input  RasterOutputData input_data,
    output logic            fifo_full,
    input  logic            shadow_fifo_full,
    output logic            shadow_strobe,
    output Ray              shadow_ray,
    input  logic            shadow_done,
    input  logic            shadow_hit,
    input  logic            output_fifo_full,
    output logic            valid,
    output RasterOutputData out
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Full means the pointers differ only in the wrap bit.
    localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

    logic [PW-1:0]      top_q, top_d, bot_q, bot_d;
    logic               fifo_full_q, fifo_full_d;
    RasterOutputData    mem_q [DEPTH];
    ShadowDispatchState state_q, state_d;
    RasterOutputData    cur_q, cur_d, out_q, out_d;
    Ray                 ray_q, ray_d;
    logic               strobe_q, strobe_d, valid_q, valid_d;
    logic               push, pop, empty;
    RGB8                dark_color;

    ShadowColorApply #(.SHADOW_SHIFT(SHADOW_SHIFT)) u_color (
        .color_in  (cur_q.Color),
        .hit       (shadow_hit),
        .color_out (dark_color)
    );

    always_comb begin
        empty       = (top_q == bot_q);
        push        = add_input && !fifo_full_q;
        pop         = (state_q == SDS_Idle) && !empty;
        top_d       = pop  ? top_q + PW'(1) : top_q;
        bot_d       = push ? bot_q + PW'(1) : bot_q;
        fifo_full_d = ((top_d ^ bot_d) == FULL_XOR);
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        out_d    = out_q;
        ray_d    = ray_q;
        strobe_d = 1'b0;
        valid_d  = 1'b0;
        case (state_q)
            SDS_Idle: begin
                if (!empty) begin
                    cur_d   = mem_q[top_q[AW-1:0]];
                    state_d = (cur_d.SurfaceType == ST_None) ? SDS_Output : SDS_Issue;
                end
            end
            SDS_Issue: begin
                if (!shadow_fifo_full) begin
                    strobe_d = 1'b1;
                    ray_d    = cur_q.ShadowingRay;
                    state_d  = SDS_Wait;
                end
            end
            SDS_Wait: begin
                if (shadow_done) begin
                    cur_d.Color = dark_color;
                    state_d     = SDS_Output;
                end
            end
            SDS_Output: begin
                if (!output_fifo_full) begin
                    out_d   = cur_q;
                    valid_d = 1'b1;
                    state_d = SDS_Idle;
                end
            end
            default: state_d = SDS_Idle;
        endcase
    end

    // Entry storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[bot_q[AW-1:0]] <= input_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SDS_Idle;
            top_q       <= '0;
            bot_q       <= '0;
            fifo_full_q <= 1'b0;
            cur_q       <= '0;
            out_q       <= '0;
            ray_q       <= '0;
            strobe_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            fifo_full_q <= fifo_full_d;
            cur_q       <= cur_d;
            out_q       <= out_d;
            ray_q       <= ray_d;
            strobe_q    <= strobe_d;
            valid_q     <= valid_d;
        end
    end

    assign fifo_full     = fifo_full_q;
    assign shadow_strobe = strobe_q;
    assign shadow_ray    = ray_q;
    assign valid         = valid_q;
    assign out           = out_q;

endmodule

// File: tb/tb_shadow_dispatch.sv
// Scoreboarded bench: expected fragments and rays are queued at push time and checked by monitor/responder processes.
module tb_shadow_dispatch;
    import shadow_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int SHIFT = 1;

    logic            clk;
    logic            resetn;
    logic            add_input;
    RasterOutputData input_data;
    logic            fifo_full;
    logic            shadow_fifo_full;
    logic            shadow_strobe;
    Ray              shadow_ray;
    logic            shadow_done;
    logic            shadow_hit;
    logic            output_fifo_full;
    logic            valid;
    RasterOutputData out;

    shadow_dispatch #(.DEPTH(DEPTH), .SHADOW_SHIFT(SHIFT)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .add_input        (add_input),
        .input_data       (input_data),
        .fifo_full        (fifo_full),
        .shadow_fifo_full (shadow_fifo_full),
        .shadow_strobe    (shadow_strobe),
        .shadow_ray       (shadow_ray),
        .shadow_done      (shadow_done),
        .shadow_hit       (shadow_hit),
        .output_fifo_full (output_fifo_full),
        .valid            (valid),
        .out              (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    RasterOutputData exp_q[$];
    Ray              ray_q[$];
    int valid_cnt = 0, strobe_cnt = 0;
    int last_valid_edge = -1, last_strobe_edge = -1, last_done_edge = -1;
    int resp_hold = 0, rst_gen = 0, stray_cnt = 0, max_dly = 0;

    task automatic chk(string nm, logic [255:0] act, logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Bench policy: the shadow tester reports occlusion from one bit of the ray.
    function automatic logic hit_of(Ray r);
        return r.Direction.z[0];
    endfunction

    function automatic RasterOutputData model(RasterOutputData f);
        RasterOutputData e = f;
        int div = 1 << SHIFT;
        if (f.SurfaceType != ST_None && hit_of(f.ShadowingRay)) begin
            e.Color.r = 8'(int'(f.Color.r) / div);
            e.Color.g = 8'(int'(f.Color.g) / div);
            e.Color.b = 8'(int'(f.Color.b) / div);
        end
        return e;
    endfunction

    function automatic RasterOutputData mk(SurfaceType_t st, logic [7:0] r, logic [7:0] g,
                                           logic [7:0] b, logic hit);
        RasterOutputData f;
        logic [63:0] w;
        w = {$urandom(), $urandom()}; f.Position = w[47:0];
        w = {$urandom(), $urandom()}; f.Normal = w[47:0];
        w = {$urandom(), $urandom()}; f.ShadowingRay.Origin = w[47:0];
        w = {$urandom(), $urandom()}; f.ShadowingRay.Direction = w[47:0];
        f.ShadowingRay.Direction.z[0] = hit;
        f.Color.r = r;
        f.Color.g = g;
        f.Color.b = b;
        f.SurfaceType = st;
        return f;
    endfunction

    function automatic SurfaceType_t rand_st();
        case ($urandom_range(0, 2))
            0:       return ST_None;
            1:       return ST_Diffuse;
            default: return ST_Mirror;
        endcase
    endfunction

    // Monitor: every valid pulse must match the oldest expected fragment.
    initial begin
        RasterOutputData e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                valid_cnt++;
                last_valid_edge = cyc;
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_fragment", 256'(out), 256'(e));
                end
            end
        end
    end

    // Shadow tester model: checks each issued ray, answers after a random delay.
    initial begin
        int   stray_served = 0;
        bit   pend = 0;
        Ray   pend_ray, r;
        logic pend_hit = 1'b0;
        int   pend_dly = 0, pend_gen = 0;
        shadow_done = 1'b0;
        shadow_hit  = 1'b0;
        forever begin
            @(negedge clk);
            shadow_done = 1'b0;
            shadow_hit  = 1'b0;
            if (stray_cnt != stray_served) begin
                stray_served = stray_cnt;
                shadow_done  = 1'b1;
                shadow_hit   = 1'b1;
            end
            if (pend) begin
                if (pend_gen != rst_gen) pend = 0;
                else if (resp_hold == 0) begin
                    if (pend_dly > 0) pend_dly--;
                    else begin
                        chk("ray_stable", 256'(shadow_ray), 256'(pend_ray));
                        shadow_done    = 1'b1;
                        shadow_hit     = pend_hit;
                        last_done_edge = cyc + 1;
                        pend = 0;
                    end
                end
            end
            if (shadow_strobe === 1'b1) begin
                strobe_cnt++;
                last_strobe_edge = cyc;
                if (ray_q.size() == 0) chk("unexpected_strobe", 1, 0);
                else begin
                    r = ray_q.pop_front();
                    chk("shadow_ray", 256'(shadow_ray), 256'(r));
                    pend     = 1;
                    pend_ray = r;
                    pend_hit = hit_of(r);
                    pend_dly = int'($urandom_range(max_dly, 0));
                    pend_gen = rst_gen;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frag(RasterOutputData f);
        add_input  = 1'b1;
        input_data = f;
        exp_q.push_back(model(f));
        if (f.SurfaceType != ST_None) ray_q.push_back(f.ShadowingRay);
        tick();
        add_input = 1'b0;
    endtask

    task automatic wait_valid(int n, int budget, string nm);
        int k = 0;
        while (valid_cnt < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 256'(valid_cnt >= n), 1);
    endtask

    initial begin
        RasterOutputData f;
        int acc, v0, s0, rel, sent, k;

        resetn = 1'b1; add_input = 1'b0; input_data = '0;
        shadow_fifo_full = 1'b0; output_fifo_full = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) tick();
        chk("rst_fifo_full", 256'(fifo_full), 0);
        chk("rst_valid", 256'(valid), 0);
        chk("rst_strobe", 256'(shadow_strobe), 0);
        chk("rst_out", 256'(out), 0);
        chk("rst_ray", 256'(shadow_ray), 0);
        resetn = 1'b1;
        tick();

        // Unlit fragment: two-edge latency, no shadow request.
        v0 = valid_cnt; s0 = strobe_cnt; acc = cyc + 1;
        push_frag(mk(ST_None, 8'd17, 8'd34, 8'd51, 1'b1));
        wait_valid(v0 + 1, 20, "none_valid_seen");
        chk("none_latency", 256'(last_valid_edge - acc), 2);
        chk("none_no_strobe", 256'(strobe_cnt), 256'(s0));

        // Lit fragment, occluded and then unoccluded.
        max_dly = 2;
        v0 = valid_cnt; s0 = strobe_cnt;
        push_frag(mk(ST_Diffuse, 8'd200, 8'd100, 8'd51, 1'b1));
        wait_valid(v0 + 1, 30, "hit_valid_seen");
        chk("hit_color", 256'(out.Color), 256'({8'd100, 8'd50, 8'd25}));
        chk("hit_latency", 256'(last_valid_edge - last_done_edge), 1);
        chk("hit_one_strobe", 256'(strobe_cnt), 256'(s0 + 1));
        v0 = valid_cnt;
        push_frag(mk(ST_Mirror, 8'd200, 8'd100, 8'd51, 1'b0));
        wait_valid(v0 + 1, 30, "miss_valid_seen");
        chk("miss_color", 256'(out.Color), 256'({8'd200, 8'd100, 8'd51}));

        // Shadow tester stalled for 10 cycles with a stray done in the middle.
        shadow_fifo_full = 1'b1;
        v0 = valid_cnt; s0 = strobe_cnt;
        push_frag(mk(ST_Diffuse, 8'd90, 8'd60, 8'd255, 1'b0));
        for (int i = 0; i < 10; i++) begin
            if (i == 4) stray_cnt++;
            tick();
        end
        chk("stall_no_strobe", 256'(strobe_cnt), 256'(s0));
        chk("stall_no_valid", 256'(valid_cnt), 256'(v0));
        rel = cyc + 1;
        shadow_fifo_full = 1'b0;
        wait_valid(v0 + 1, 30, "stall_valid_seen");
        chk("strobe_after_release", 256'(last_strobe_edge), 256'(rel));

        // Output blocked: one fragment held in the FSM, then four fill the queue and a fifth is dropped.
        output_fifo_full = 1'b1;
        v0 = valid_cnt;
        push_frag(mk(ST_None, 8'd1, 8'd2, 8'd3, 1'b0));
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("not_full_before_4th", 256'(fifo_full), 0);
            push_frag(mk(rand_st(), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom)));
        end
        chk("full_after_4th", 256'(fifo_full), 1);
        add_input  = 1'b1;
        input_data = mk(ST_None, 8'hEE, 8'hEE, 8'hEE, 1'b0);
        tick();
        add_input = 1'b0;
        chk("full_holds", 256'(fifo_full), 1);
        chk("blocked_no_valid", 256'(valid_cnt), 256'(v0));
        output_fifo_full = 1'b0;
        wait_valid(v0 + 5, 200, "drain_valid_seen");
        repeat (20) tick();
        chk("drain_exact_count", 256'(valid_cnt), 256'(v0 + 5));
        chk("drain_not_full", 256'(fifo_full), 0);

        // Reset while waiting on the shadow tester with a full queue behind it.
        resp_hold = 1;
        s0 = strobe_cnt;
        push_frag(mk(ST_Diffuse, 8'd40, 8'd40, 8'd40, 1'b1));
        k = 0;
        while (strobe_cnt == s0 && k < 20) begin tick(); k++; end
        chk("rst_case_strobe", 256'(strobe_cnt), 256'(s0 + 1));
        tick();
        for (int i = 0; i < DEPTH; i++) push_frag(mk(ST_None, 8'd5, 8'd6, 8'd7, 1'b0));
        chk("rst_case_full", 256'(fifo_full), 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_full", 256'(fifo_full), 0);
        chk("async_rst_valid", 256'(valid), 0);
        chk("async_rst_ray", 256'(shadow_ray), 0);
        chk("async_rst_out", 256'(out), 0);
        exp_q.delete();
        ray_q.delete();
        rst_gen++;
        resp_hold = 0;
        tick();
        resetn = 1'b1;
        v0 = valid_cnt; s0 = strobe_cnt;
        stray_cnt++;
        repeat (10) tick();
        chk("post_rst_no_valid", 256'(valid_cnt), 256'(v0));
        chk("post_rst_no_strobe", 256'(strobe_cnt), 256'(s0));
        push_frag(mk(ST_None, 8'd9, 8'd8, 8'd7, 1'b0));
        wait_valid(v0 + 1, 20, "post_rst_valid_seen");

        // Randomised traffic with random back-pressure on both sides.
        max_dly = 3;
        v0 = valid_cnt;
        sent = 0;
        k = 0;
        while (sent < 150 && k < 5000) begin
            shadow_fifo_full = ($urandom_range(0, 3) == 0);
            output_fifo_full = ($urandom_range(0, 3) == 0);
            if ((sent - (valid_cnt - v0)) < DEPTH && $urandom_range(0, 1) == 1) begin
                push_frag(mk(rand_st(), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom)));
                sent++;
            end else tick();
            k++;
        end
        shadow_fifo_full = 1'b0;
        output_fifo_full = 1'b0;
        chk("rand_all_sent", 256'(sent), 150);
        wait_valid(v0 + sent, 3000, "rand_drain_seen");
        repeat (5) tick();
        chk("rand_exp_empty", 256'(exp_q.size()), 0);
        chk("rand_ray_empty", 256'(ray_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
